keypad_key_injector: RTL and testbench

// - Emulates the 4x4 matrix keypad from the scanning side's point of view: watches the column drive, answers on the row lines.
// - Lets a host or test sequencer play queued key codes into the calculator without physical switches.
// - Sits between the calculator's column outputs (IO_P4_COL) and its row inputs (IO_P4_ROW).
// - Holds each key for a fixed press time, then releases it for a fixed gap time, so the keypad poller sees clean press/release edges.

---
 rtl/keypad_key_injector.sv | 166 ++++++++++++++++
 tb/tb_keypad_key_injector.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_key_injector.sv
// keypad_key_injector
// Stands in for a 4x4 matrix keypad on the scanning side. Key codes are
// queued by a host. Each key is held pressed for HOLD_CYCLES clocks and then
// released for GAP_CYCLES clocks, so the poller sees clean press and release
// edges. While a key is pressed, the key's row line is pulled low whenever
// the poller drives that key's column low.
module keypad_key_injector #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 50000,
  parameter int GAP_CYCLES  = 50000,
  parameter int CNT_W       = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          key_valid,
  input  logic [3:0]                    key_code,
  output logic                          key_ready,
  input  logic                          flush,
  input  logic [3:0]                    col_in,
  output logic [3:0]                    row_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    RELEASE
  } state_t;

  // Key map: {row, col}. This table must stay identical to keypad_encoder.
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: F 0 E D
  function automatic logic [3:0] key_pos(input logic [3:0] code);
    key_pos = 4'h0;
    case (code)
      4'h1: key_pos = {2'd0, 2'd0};
      4'h2: key_pos = {2'd0, 2'd1};
      4'h3: key_pos = {2'd0, 2'd2};
      4'hA: key_pos = {2'd0, 2'd3};
      4'h4: key_pos = {2'd1, 2'd0};
      4'h5: key_pos = {2'd1, 2'd1};
      4'h6: key_pos = {2'd1, 2'd2};
      4'hB: key_pos = {2'd1, 2'd3};
      4'h7: key_pos = {2'd2, 2'd0};
      4'h8: key_pos = {2'd2, 2'd1};
      4'h9: key_pos = {2'd2, 2'd2};
      4'hC: key_pos = {2'd2, 2'd3};
      4'hF: key_pos = {2'd3, 2'd0};
      4'h0: key_pos = {2'd3, 2'd1};
      4'hE: key_pos = {2'd3, 2'd2};
      4'hD: key_pos = {2'd3, 2'd3};
      default: key_pos = 4'h0;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       act_row, act_col;

  logic [3:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push, pop;
  logic [3:0]       head_pos;

  // The queue is full when it holds FIFO_DEPTH keys. A pop in the same cycle
  // does not free a slot for the host.
  assign key_ready  = (count_q != CW'(FIFO_DEPTH));
  assign push       = key_valid & key_ready & ~flush;
  assign pop        = (state_q == IDLE) & (count_q != '0) & ~flush;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) | (count_q != '0);
  assign head_pos   = key_pos(mem[rd_ptr]);

  // Queue pointers and occupancy. flush discards everything, including a
  // push in the same cycle.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the pre-edge values and the order of statements does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Queue storage. Entries are only read once the occupancy says they are valid.
  // NOTE: the storage array has no reset. The pointers and count define
  // which entries are valid, and leaving the array unreset keeps it in plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= key_code;
  end

  // FSM state, hold/gap counter, and the decoded position of the active key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      act_row <= 2'd0;
      act_col <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pop) begin
        act_row <= head_pos[3:2];
        act_col <= head_pos[1:0];
      end
    end
  end

  // Next-state logic: IDLE -> PRESS (HOLD_CYCLES) -> RELEASE (GAP_CYCLES) -> IDLE.
  // NOTE: every signal is assigned a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = PRESS;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      PRESS: begin
        if (cnt_q == '0) begin
          state_d = RELEASE;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Row response: pull the active key's row low while the key is pressed
  // and its column is among the columns being driven low.
  always_comb begin
    row_out = 4'hF;
    if (state_q == PRESS && !col_in[act_col]) row_out[act_row] = 1'b0;
  end

endmodule

// File: tb/tb_keypad_key_injector.sv
// tb_keypad_key_injector
// Directed bench for keypad_key_injector with HOLD=4, GAP=2, FIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_keypad_key_injector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       flush;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       busy;
  logic [2:0] fifo_count;

  int tests  = 0;
  int failed = 0;

  keypad_key_injector #(
    .FIFO_DEPTH (4),
    .HOLD_CYCLES(4),
    .GAP_CYCLES (2),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .flush     (flush),
    .col_in    (col_in),
    .row_out   (row_out),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] code;
    logic [3:0] col;   // one-cold column drive that selects the key
    logic [3:0] row;   // expected row_out while pressed
  } vec_t;

  vec_t vecs [16];

  // Arrays that describe one back-to-back sequence for run_seq.
  logic [3:0] s_code  [6];
  logic       s_ready [6];
  int         s_cnt   [6];
  logic [3:0] s_col   [5];
  logic [3:0] s_row   [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plays one key at a negedge with the DUT idle. Checks the idle row, the
  // pressed row, the wrong-column row, and that busy clears after 7 cycles.
  task automatic run_vec(input vec_t v, input string tag);
    key_valid = 1'b1;
    key_code  = v.code;
    col_in    = 4'h0;
    #1 check({tag, " ready"}, key_ready, 1'b1);
    @(negedge clk);
    key_valid = 1'b0;
    #1 check({tag, " queued row"}, row_out, 4'hF);
    check({tag, " queued busy"}, busy, 1'b1);
    @(negedge clk);
    col_in = v.col;
    #1 check({tag, " press row"}, row_out, v.row);
    col_in = ~v.col;
    #1 check({tag, " other cols row"}, row_out, 4'hF);
    repeat (6) @(negedge clk);
    #1 check({tag, " busy done"}, busy, 1'b0);
  endtask

  // Offers s_code[0..n_offer-1] on consecutive cycles, then follows the
  // expected 4 PRESS / 2 RELEASE / 1 IDLE timeline for nk keys.
  task automatic run_seq(input int nk, input int n_offer, input string tag);
    int idx, phase;
    logic [3:0] exp_row;
    for (int n = 0; n <= 7 * nk + 2; n++) begin
      if (n < n_offer) begin
        key_valid = 1'b1;
        key_code  = s_code[n];
      end else begin
        key_valid = 1'b0;
      end
      idx   = (n < 2) ? 0 : (n - 2) / 7;
      phase = (n < 2) ? 7 : (n - 2) % 7;
      col_in  = s_col[(idx < nk) ? idx : nk - 1];
      exp_row = (idx < nk && phase < 4) ? s_row[idx] : 4'hF;
      #1;
      if (n < n_offer) begin
        check($sformatf("%s ready n=%0d", tag, n), key_ready, s_ready[n]);
        check($sformatf("%s count n=%0d", tag, n), fifo_count, s_cnt[n]);
      end
      check($sformatf("%s row n=%0d", tag, n), row_out, exp_row);
      check($sformatf("%s busy n=%0d", tag, n), busy, (n >= 1 && n < 7 * nk + 1));
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0]  = '{4'h1, 4'b1110, 4'b1110};
    vecs[1]  = '{4'h2, 4'b1101, 4'b1110};
    vecs[2]  = '{4'h3, 4'b1011, 4'b1110};
    vecs[3]  = '{4'hA, 4'b0111, 4'b1110};
    vecs[4]  = '{4'h4, 4'b1110, 4'b1101};
    vecs[5]  = '{4'h5, 4'b1101, 4'b1101};
    vecs[6]  = '{4'h6, 4'b1011, 4'b1101};
    vecs[7]  = '{4'hB, 4'b0111, 4'b1101};
    vecs[8]  = '{4'h7, 4'b1110, 4'b1011};
    vecs[9]  = '{4'h8, 4'b1101, 4'b1011};
    vecs[10] = '{4'h9, 4'b1011, 4'b1011};
    vecs[11] = '{4'hC, 4'b0111, 4'b1011};
    vecs[12] = '{4'hF, 4'b1110, 4'b0111};
    vecs[13] = '{4'h0, 4'b1101, 4'b0111};
    vecs[14] = '{4'hE, 4'b1011, 4'b0111};
    vecs[15] = '{4'hD, 4'b0111, 4'b0111};

    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; flush = 1'b0; col_in = 4'h0;
    #12;
    check("reset row", row_out, 4'hF);
    check("reset busy", busy, 1'b0);
    check("reset count", fifo_count, 3'd0);
    check("reset ready", key_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Key map: every code on its own row/column.
    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("map[%0h]", vecs[i].code));

    // Code 5 with column 1 held low: exactly 4 PRESS cycles, busy low 7 cycles after acceptance.
    key_valid = 1'b1; key_code = 4'h5; col_in = 4'b1101;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      key_valid = 1'b0;
      #1 check($sformatf("hold5 row k=%0d", k), row_out, (k >= 1 && k <= 4) ? 4'b1101 : 4'hF);
      check($sformatf("hold5 busy k=%0d", k), busy, k < 7);
    end

    // Code 5 under a column scan F,E,D,B,7: low only when column 1 is driven.
    key_valid = 1'b1; key_code = 4'h5; col_in = 4'hF;
    for (int k = 0; k <= 9; k++) begin
      logic [3:0] scan [5];
      scan[0] = 4'hF; scan[1] = 4'hE; scan[2] = 4'hD; scan[3] = 4'hB; scan[4] = 4'h7;
      @(negedge clk);
      key_valid = 1'b0;
      col_in = scan[k % 5];
      #1 check($sformatf("scan5 row k=%0d", k), row_out,
               (k >= 1 && k <= 4 && scan[k % 5] == 4'b1101) ? 4'b1101 : 4'hF);
    end
    @(negedge clk);

    // Code A: wrong column, two columns low, all columns low.
    key_valid = 1'b1; key_code = 4'hA; col_in = 4'hF;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    col_in = 4'b1110;
    #1 check("A wrong col", row_out, 4'hF);
    @(negedge clk);
    col_in = 4'b0110;
    #1 check("A two cols low", row_out, 4'b1110);
    @(negedge clk);
    col_in = 4'b0000;
    #1 check("A all cols low", row_out, 4'b1110);
    repeat (5) @(negedge clk);
    #1 check("A busy done", busy, 1'b0);

    // Queue fill: codes 1..6 offered while the first key is pressed; 6 is dropped.
    s_code[0] = 4'h1; s_code[1] = 4'h2; s_code[2] = 4'h3;
    s_code[3] = 4'h4; s_code[4] = 4'h5; s_code[5] = 4'h6;
    s_ready[0] = 1; s_ready[1] = 1; s_ready[2] = 1; s_ready[3] = 1; s_ready[4] = 1; s_ready[5] = 0;
    s_cnt[0] = 0; s_cnt[1] = 1; s_cnt[2] = 1; s_cnt[3] = 2; s_cnt[4] = 3; s_cnt[5] = 4;
    s_col[0] = 4'b1110; s_col[1] = 4'b1101; s_col[2] = 4'b1011; s_col[3] = 4'b1110; s_col[4] = 4'b1101;
    s_row[0] = 4'b1110; s_row[1] = 4'b1110; s_row[2] = 4'b1110; s_row[3] = 4'b1101; s_row[4] = 4'b1101;
    run_seq(5, 6, "fill");

    // Sequence 1, A, 2 back to back: row 0, columns 0, 3, 1.
    s_code[0] = 4'h1; s_code[1] = 4'hA; s_code[2] = 4'h2;
    s_ready[0] = 1; s_ready[1] = 1; s_ready[2] = 1;
    s_cnt[0] = 0; s_cnt[1] = 1; s_cnt[2] = 1;
    s_col[0] = 4'b1110; s_col[1] = 4'b0111; s_col[2] = 4'b1101;
    s_row[0] = 4'b1110; s_row[1] = 4'b1110; s_row[2] = 4'b1110;
    run_seq(3, 3, "seq1A2");

    // flush mid-PRESS with two keys queued; a push in the flush cycle is discarded.
    col_in = 4'h0;
    key_valid = 1'b1; key_code = 4'h1;
    @(negedge clk); key_code = 4'h2;
    @(negedge clk); key_code = 4'h3;
    @(negedge clk); key_code = 4'h4; flush = 1'b1;
    #1 check("pre-flush row", row_out, 4'b1110);
    check("pre-flush count", fifo_count, 3'd2);
    @(negedge clk);
    flush = 1'b0; key_valid = 1'b0;
    #1 check("flush row", row_out, 4'hF);
    check("flush count", fifo_count, 3'd0);
    check("flush busy", busy, 1'b0);
    check("flush ready", key_ready, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1 check($sformatf("post-flush row k=%0d", k), row_out, 4'hF);
      check($sformatf("post-flush busy k=%0d", k), busy, 1'b0);
    end

    // Asynchronous reset between clock edges in mid-PRESS.
    key_valid = 1'b1; key_code = 4'h5; col_in = 4'b1101;
    @(negedge clk); key_valid = 1'b0;
    @(negedge clk);
    #1 check("pre-reset row", row_out, 4'b1101);
    #2 rst_n = 1'b0;
    #1 check("async reset row", row_out, 4'hF);
    check("async reset busy", busy, 1'b0);
    check("async reset count", fifo_count, 3'd0);
    check("async reset ready", key_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("after reset row", row_out, 4'hF);
    run_vec(vecs[5], "after reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
